// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the two frame requesters, the scheduler and the UART TX load port.
// Handshakes: a requester holds *_VALID/*_DATA/*_TWO until it sees a one-cycle *_ACK (frame
// captured); the scheduler holds TX_D_VALID/TX_P_DATA until TX_BUSY is sampled rising.
interface uart_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    REQ0_VALID;
    logic [2*DATA_WIDTH-1:0] REQ0_DATA;
    logic                    REQ0_TWO;
    logic                    REQ0_ACK;
    logic                    REQ1_VALID;
    logic [2*DATA_WIDTH-1:0] REQ1_DATA;
    logic                    REQ1_TWO;
    logic                    REQ1_ACK;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VALID;
    logic                    TX_BUSY;
    logic                    SCHED_BUSY;
    logic                    TX_ERR;

    modport master (
        input  REQ0_VALID, REQ0_DATA, REQ0_TWO,
        input  REQ1_VALID, REQ1_DATA, REQ1_TWO,
        input  TX_BUSY,
        output REQ0_ACK, REQ1_ACK,
        output TX_P_DATA, TX_D_VALID, SCHED_BUSY, TX_ERR
    );

    modport slave (
        output REQ0_VALID, REQ0_DATA, REQ0_TWO,
        output REQ1_VALID, REQ1_DATA, REQ1_TWO,
        output TX_BUSY,
        input  REQ0_ACK, REQ1_ACK,
        input  TX_P_DATA, TX_D_VALID, SCHED_BUSY, TX_ERR
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX between two requesters, 1- or 2-byte frames, low byte first.
// Optional busy-rise timeout with sticky TX_ERR is enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                CLK,
    input  logic                RST,
    uart_tx_scheduler_if.master bus,
    output logic [1:0]          dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    idx_q, idx_d;
    logic [2*DATA_WIDTH-1:0] data_q, data_d;
    logic                    two_q, two_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic                    armed_q, armed_d;
    logic                    grant1;
    logic [DATA_WIDTH-1:0]   byte_sel;

`ifdef UART_SCHED_TIMEOUT_EN
    // Abort on the cycle the counter would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
`endif

    assign grant1 = bus.REQ1_VALID && (!bus.REQ0_VALID || !last_grant_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            idx_q        <= 1'b0;
            data_q       <= '0;
            two_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            armed_q      <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            two_q        <= two_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            armed_q      <= armed_d;
`ifdef UART_SCHED_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    // armed_q: TX_BUSY has been seen low during this ISSUE, so the next high sample is a genuine
    // rise caused by our load rather than the tail of a previous transfer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        data_d       = data_q;
        two_d        = two_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        armed_d      = armed_q;
`ifdef UART_SCHED_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.REQ0_VALID || bus.REQ1_VALID) begin
                    if (grant1) begin
                        data_d       = bus.REQ1_DATA;
                        two_d        = bus.REQ1_TWO;
                        ack1_d       = 1'b1;
                        last_grant_d = 1'b1;
                    end else begin
                        data_d       = bus.REQ0_DATA;
                        two_d        = bus.REQ0_TWO;
                        ack0_d       = 1'b1;
                        last_grant_d = 1'b0;
                    end
                    idx_d   = 1'b0;
                    armed_d = !bus.TX_BUSY;
                    state_d = S_ISSUE;
`ifdef UART_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_ISSUE: begin
                if (bus.TX_BUSY && armed_q) begin
                    state_d = S_DRAIN;
                end else begin
                    if (!bus.TX_BUSY) begin
                        armed_d = 1'b1;
                    end
`ifdef UART_SCHED_TIMEOUT_EN
                    if (cnt_q == TO_LAST) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        idx_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            S_DRAIN: begin
                if (!bus.TX_BUSY) begin
                    if (two_q && !idx_q) begin
                        idx_d   = 1'b1;
                        armed_d = 1'b1;
                        state_d = S_ISSUE;
`ifdef UART_SCHED_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        idx_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign byte_sel = idx_q ? data_q[2*DATA_WIDTH-1:DATA_WIDTH] : data_q[DATA_WIDTH-1:0];

    assign bus.TX_D_VALID = (state_q == S_ISSUE);
    assign bus.TX_P_DATA  = (state_q == S_ISSUE) ? byte_sel : '0;
    assign bus.SCHED_BUSY = (state_q != S_IDLE);
    assign bus.REQ0_ACK   = ack0_q;
    assign bus.REQ1_ACK   = ack1_q;
`ifdef UART_SCHED_TIMEOUT_EN
    assign bus.TX_ERR     = err_q;
`else
    assign bus.TX_ERR     = 1'b0;
`endif
    assign dbg_state_o    = state_q;
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter between two requesters: REQ0 (register-file read path) and REQ1 (ALU result path).
- Round-robin arbitration; one- or two-byte frames.
- Drives the UART TX parallel-load handshake and sequences bytes low-first.
- Sits in the TX-side system domain between the system controller's data sources and the UART TX data/valid/busy interface.

Parameters:
DATA_WIDTH, 8, UART byte width; request payload is 2*DATA_WIDTH
TIMEOUT_W, 8, width of busy-rise timeout counter (used only with the optional feature)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
REQ0_VALID  in  1  requester 0 has a frame pending
REQ0_DATA  in  2*DATA_WIDTH  payload; low byte sent first
REQ0_TWO  in  1  1 = two-byte frame, 0 = low byte only
REQ0_ACK  out  1  one-cycle pulse: frame captured, requester may drop or replace data
REQ1_VALID, REQ1_DATA, REQ1_TWO, REQ1_ACK  same as REQ0 for requester 1
TX_P_DATA  out  DATA_WIDTH  byte to UART TX
TX_D_VALID  out  1  load request to UART TX
TX_BUSY  in  1  UART TX busy, already synchronized into CLK
SCHED_BUSY  out  1  high whenever state != IDLE
TX_ERR  out  1  sticky abort flag; only exists under the optional feature, otherwise tied 0

Behaviour:
- Reset (RST=0, asynchronous):
  - State=IDLE; all outputs 0.
  - Round-robin pointer last_grant=1, so REQ0 wins the first contention.
  - Byte index 0; capture registers 0.
  - Reset mid-frame abandons the frame silently; TX_D_VALID drops immediately.
- IDLE:
  - At a rising edge with any VALID high, grant a requester:
    - Only one valid: grant it.
    - Both valid: grant the one != last_grant.
  - Same edge: capture DATA and TWO, set last_grant, register ACK. ACK is high for exactly the next cycle.
  - Next state ISSUE with byte index 0.
  - VALID with TX_BUSY already high is still granted; ISSUE waits.
- ISSUE:
  - TX_D_VALID=1; TX_P_DATA = captured low byte (idx 0) or high byte (idx 1).
  - Held until a rising edge samples TX_BUSY=1, then TX_D_VALID=0 on the following cycle and next state DRAIN.
  - TX_P_DATA is stable for the whole ISSUE state.
- DRAIN:
  - Wait for TX_BUSY=0.
  - If TWO=1 and idx=0: idx=1, go to ISSUE.
  - Else: go to IDLE. Arbitration is re-evaluated in IDLE; a back-to-back frame costs 1 IDLE cycle minimum.
- Requester VALID changes after grant are ignored until the next IDLE.
- ACK is never asserted to both requesters in the same cycle.
- SCHED_BUSY is registered with state; it is 0 only in IDLE.
- Minimum latency: VALID high at edge k → TX_D_VALID high from edge k+1.

Optional Feature:
- Macro UART_SCHED_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter runs in ISSUE and clears on state entry.
  - If it reaches all-ones without TX_BUSY=1:
    - TX_D_VALID drops and the remaining byte is discarded.
    - Next state IDLE.
    - TX_ERR sets and stays 1 until reset.
- Undefined:
  - No counter is present; ISSUE waits indefinitely.
  - TX_ERR is constant 0.

Test Plan:
- Single 1-byte frame: REQ0_VALID=1, DATA=16'h00A5, TWO=0; bench model asserts TX_BUSY 3 cycles after TX_D_VALID, holds it 20 cycles → one REQ0_ACK pulse; TX_P_DATA=8'hA5 while TX_D_VALID; SCHED_BUSY returns 0 after busy falls.
- Two-byte frame: REQ1 DATA=16'h3C7E, TWO=1 → bytes 8'h7E then 8'h3C; exactly two TX_D_VALID assertions; one REQ1_ACK.
- Contention after reset: both VALID together, held → order REQ0, REQ1, REQ0, REQ1; ACKs never overlap.
- Busy at request: TX_BUSY=1 while REQ0 is granted → TX_D_VALID stays high until TX_BUSY falls and rises again; byte 8'hA5 is not lost.
- Reset mid-frame: RST=0 during DRAIN of a 2-byte frame → all outputs 0 asynchronously; after release the high byte is never sent; REQ0 wins the next contention.
- With UART_SCHED_TIMEOUT_EN, TIMEOUT_W=4, TX_BUSY stuck 0 → TX_D_VALID drops after 15 ISSUE cycles; TX_ERR=1; state IDLE; next request is served normally.
